// File: rtl/dct_pkg.sv
// Shared constants and FSM state type for the row-to-column DCT transpose reader.
package dct_pkg;
    localparam int COEF_W    = 22;
    localparam int N         = 4;
    localparam int BLK_WORDS = 16;
    localparam int CNT_W     = 5;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;
endpackage

// File: rtl/fifo_read_pacer.sv
// Issues FIFO reads at most every other cycle so the registered empty flag is
// always current when sampled, and delays each read into a capture strobe.
module fifo_read_pacer
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic             fifo_empty,
    output logic             rd_en,
    output logic             capture,
    output logic [CNT_W-1:0] rd_cnt
);
    logic             rd_en_prev_reg;
    logic [CNT_W-1:0] rd_cnt_reg;

    assign rd_en   = enable && !fifo_empty && !rd_en_prev_reg
                     && (rd_cnt_reg < CNT_W'(BLK_WORDS));
    // FIFO data is registered, so it is valid exactly one cycle after the read.
    assign capture = rd_en_prev_reg;
    assign rd_cnt  = rd_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_prev_reg <= 1'b0;
            rd_cnt_reg     <= '0;
        end else begin
            rd_en_prev_reg <= rd_en;
            if (clear) begin
                rd_cnt_reg <= '0;
            end else if (rd_en) begin
                rd_cnt_reg <= rd_cnt_reg + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/dct_transpose_reader.sv
// Collects a 4x4 coefficient block from the FIFO and hands it out as four vectors.
// Build option DCT_RDR_TRANSPOSE_EN: emit columns instead of rows.
module dct_transpose_reader
    import dct_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [COEF_W-1:0]     fifo_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*COEF_W-1:0]   out_data,
    output logic                  out_last,
    output logic                  blk_busy
);
    state_t             state_reg, state_next;
    logic [1:0]         vec_reg, vec_next;
    logic [3:0]         wr_cnt_reg;
    logic [COEF_W-1:0]  m_reg [BLK_WORDS];
    logic               rd_en;
    logic               capture;
    logic               last_word;
    logic [CNT_W-1:0]   rd_cnt;

    fifo_read_pacer u_pacer (
        .clk        (clk),
        .rst        (rst),
        .enable     (state_reg == FILL),
        .clear      (last_word),
        .fifo_empty (fifo_empty),
        .rd_en      (rd_en),
        .capture    (capture),
        .rd_cnt     (rd_cnt)
    );

    assign fifo_rd_en = rd_en;
    assign last_word  = capture && (state_reg == FILL) && (wr_cnt_reg == 4'd15);
    assign blk_busy   = (state_reg == DRAIN) || (rd_cnt != '0) || rd_en;

    // m_reg is row-major: entry {row, col} holds m[row][col]; wr_cnt wraps to 0 after word 15.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_reg <= '0;
            for (int i = 0; i < BLK_WORDS; i++) begin
                m_reg[i] <= '0;
            end
        end else if (capture && (state_reg == FILL)) begin
            m_reg[wr_cnt_reg] <= fifo_dout;
            wr_cnt_reg        <= wr_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FILL;
            vec_reg   <= '0;
        end else begin
            state_reg <= state_next;
            vec_reg   <= vec_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        vec_next   = vec_reg;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        case (state_reg)
            FILL: begin
                if (last_word) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (vec_reg == 2'd3);
                if (out_ready) begin
                    vec_next = vec_reg + 2'd1;
                    if (vec_reg == 2'd3) begin
                        state_next = FILL;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_elem
        localparam logic [1:0] EL = 2'(gi);
        logic [3:0] idx;
`ifdef DCT_RDR_TRANSPOSE_EN
        assign idx = {EL, vec_reg};
`else
        assign idx = {vec_reg, EL};
`endif
        assign out_data[gi*COEF_W +: COEF_W] = out_valid ? m_reg[idx] : '0;
    end
endmodule

// File: tb/tb_dct_transpose_reader.sv
// Randomized bench for dct_transpose_reader with a behavioural FIFO and block scoreboard.
module tb_dct_transpose_reader;
    import dct_pkg::*;

    localparam int W = COEF_W;
`ifdef DCT_RDR_TRANSPOSE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [W-1:0]     fifo_dout;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N*W-1:0]   out_data;
    logic             out_last;
    logic             blk_busy;

    always #5 clk = ~clk;

    dct_transpose_reader dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .blk_busy   (blk_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stimulus controls (written only by the main process)
    logic prod_en   = 1'b0;
    logic prod_rand = 1'b0;
    logic data_mode = 1'b0;
    logic rand_ready = 1'b0;
    int   push_limit = 1 << 30;

    // Behavioural 4-deep FIFO with registered data and a one-edge-late empty flag
    logic [W-1:0] fq[$];
    logic [W-1:0] popped[$];
    int           pushed = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete();
            popped.delete();
            pushed = 0;
            fifo_empty <= 1'b1;
            fifo_dout  <= '0;
        end else begin
            fifo_empty <= (fq.size() == 0);
            if (fifo_rd_en) begin
                check("pop_nonempty", fq.size() != 0, 1'b1);
                if (fq.size() != 0) begin
                    fifo_dout <= fq[0];
                    popped.push_back(fq[0]);
                    void'(fq.pop_front());
                end
            end
            if (prod_en && pushed < push_limit && fq.size() < 4
                && (!prod_rand || $urandom_range(0, 3) != 0)) begin
                fq.push_back(data_mode ? W'($urandom) : W'(pushed));
                pushed++;
            end
        end
    end

    // Output monitor: each accepted vector is compared to the block formed by popped words
    int             vj = 0;
    int             base = 0;
    int             blocks_done = 0;
    int             cyc = 0;
    logic [N*W-1:0] acc_data[$];
    int             acc_cyc[$];
    logic           prev_stall = 1'b0;
    logic [N*W-1:0] prev_data;
    logic           prev_last;
    logic [N*W-1:0] exp_vec;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            vj = 0;
            base = 0;
            prev_stall = 1'b0;
        end else begin
            if (fifo_rd_en) check("rd_while_empty", fifo_empty, 1'b0);
            if (out_valid) check("rd_in_drain", fifo_rd_en, 1'b0);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                check("blk_avail", popped.size() >= base + BLK_WORDS, 1'b1);
                exp_vec = '0;
                if (popped.size() >= base + BLK_WORDS) begin
                    for (int i = 0; i < N; i++) begin
                        exp_vec[i*W +: W] = TR ? popped[base + i*N + vj] : popped[base + vj*N + i];
                    end
                end
                check("vec_data", out_data, exp_vec);
                check("vec_last", out_last, vj == N - 1);
                $display("vec blk=%0d j=%0d data=%h last=%b", blocks_done, vj, out_data, out_last);
                acc_data.push_back(out_data);
                acc_cyc.push_back(cyc);
                vj++;
                if (vj == N) begin
                    vj = 0;
                    base += BLK_WORDS;
                    blocks_done++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_valid(input int limit);
        int k = 0;
        while (!out_valid && k < limit) begin
            step();
            k++;
        end
        check("valid_timeout", out_valid, 1'b1);
    endtask

    task automatic wait_blocks(input int target, input int limit);
        int k = 0;
        while (blocks_done < target && k < limit) begin
            step();
            k++;
        end
        check("blocks_timeout", blocks_done >= target, 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int a0;
        int n0;
        int tgt;
        logic [N*W-1:0] v0_exp, v3_exp;

        // Reset state
        step();
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_last", out_last, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_rd_en", fifo_rd_en, 1'b0);
        check("rst_busy", blk_busy, 1'b0);
        rst = 1'b0;

        // Single counting block, full throughput
        data_mode = 1'b0;
        prod_en   = 1'b1;
        out_ready = 1'b1;
        a0 = acc_data.size();
        k = 0;
        while (!fifo_rd_en && k < 20) begin
            step();
            k++;
        end
        check("first_rd", fifo_rd_en, 1'b1);
        check("busy_on_rd", blk_busy, 1'b1);
        k = 0;
        while (!out_valid && k < 60) begin
            step();
            k++;
        end
        check("fill_latency", k, 32);
        wait_blocks(1, 20);
        if (TR) begin
            v0_exp = {22'hC, 22'h8, 22'h4, 22'h0};
            v3_exp = {22'hF, 22'hB, 22'h7, 22'h3};
        end else begin
            v0_exp = {22'h3, 22'h2, 22'h1, 22'h0};
            v3_exp = {22'hF, 22'hE, 22'hD, 22'hC};
        end
        check("blk0_vec0", acc_data[a0], v0_exp);
        check("blk0_vec3", acc_data[a0 + 3], v3_exp);
        check("drain_4_cycles", acc_cyc[a0 + 3] - acc_cyc[a0], 3);

        // Asynchronous reset asserted mid-cycle while a block is waiting in DRAIN
        out_ready = 1'b0;
        wait_valid(100);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_data", out_data, '0);
        check("arst_last", out_last, 1'b0);
        check("arst_busy", blk_busy, 1'b0);
        check("arst_rd_en", fifo_rd_en, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Backpressure at vector 1
        data_mode = 1'b1;
        tgt = blocks_done + 1;
        wait_valid(100);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n0 = acc_data.size();
        repeat (5) begin
            step();
            check("bp_valid", out_valid, 1'b1);
            check("bp_no_accept", acc_data.size(), n0);
        end
        out_ready = 1'b1;
        step();
        check("bp_accept", acc_data.size(), n0 + 1);
        wait_blocks(tgt, 20);

        // FIFO underrun after word 6
        push_limit = 7;
        pulse_reset();
        tgt = blocks_done + 1;
        k = 0;
        while (!(popped.size() == 7 && fifo_empty) && k < 100) begin
            step();
            k++;
        end
        check("stall_reached", popped.size() == 7 && fifo_empty, 1'b1);
        repeat (10) begin
            step();
            check("stall_no_rd", fifo_rd_en, 1'b0);
            check("stall_no_valid", out_valid, 1'b0);
            check("stall_busy", blk_busy, 1'b1);
        end
        push_limit = 1 << 30;
        wait_blocks(tgt, 100);

        // Reset after word 9 of the following block
        k = 0;
        while (popped.size() < BLK_WORDS + 10 && k < 100) begin
            step();
            k++;
        end
        step();
        n0 = acc_data.size();
        rst = 1'b1;
        step();
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", blk_busy, 1'b0);
        step();
        rst = 1'b0;
        tgt = blocks_done + 1;
        wait_blocks(tgt, 100);
        check("post_rst_vectors", acc_data.size() - n0, 4);

        // Random producer gaps and random backpressure
        prod_rand  = 1'b1;
        rand_ready = 1'b1;
        wait_blocks(blocks_done + 5, 3000);
        rand_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
